pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush, load-use bubble.
// Latency: control outputs are combinational from state + inputs; state updates on Clk rise.
// Backpressure: an outstanding data access freezes every stage; timeout halts until reset.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall / flush performance counters).
module pipeline_hazard_controller #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        Uses_Rt_ID,
  input  logic        MemRead_EX,
  input  logic [4:0]  Write_Register_EX,
  input  logic        Branch_MEM,
  input  logic        Zero_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        Mem_Ack,
  output logic        Mem_Req,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        PCSrc,
  output logic        Mem_Err,
  output logic [31:0] Stall_Cycles,
  output logic [31:0] Flush_Count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  logic w_mem_req;
  logic w_freeze;
  logic w_branch_taken;
  logic w_load_use;

  // An access is requested whenever MEM holds a load/store, except once halted.
  assign w_mem_req      = (MemRead_MEM | MemWrite_MEM) & (r_state != ST_HALT);
  // Ack without a request is meaningless, so only an unacknowledged request freezes.
  assign w_freeze       = w_mem_req & ~Mem_Ack;
  assign w_branch_taken = Branch_MEM & Zero_MEM;
  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign w_load_use     = MemRead_EX & (Write_Register_EX != 5'd0) &
                          ((Write_Register_EX == Rs_ID) |
                           (Uses_Rt_ID & (Write_Register_EX == Rt_ID)));

  // Control decode, priority: reset > halt/freeze > taken branch > load-use > advance.
  // Outputs stay combinational because the ack must release the freeze in the same cycle.
  always_comb begin
    PCWrite      = 1'b0;
    IF_ID_Write  = 1'b0;
    ID_EX_Write  = 1'b0;
    EX_MEM_Write = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    PCSrc        = 1'b0;
    if (!Reset_n) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if ((r_state == ST_HALT) || w_freeze) begin
      PCWrite = 1'b0;
    end else if (w_branch_taken) begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
      PCSrc        = 1'b1;
    end else if (w_load_use) begin
      // Hold PC and IF/ID, let the load move on, and bubble ID/EX exactly once.
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
    end
  end

  assign Mem_Req = Reset_n & w_mem_req;
  assign Mem_Err = r_mem_err;

  // Memory-wait FSM: counts unacknowledged cycles and halts after MEM_TIMEOUT of them.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_freeze) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (w_freeze) begin
            if (r_wait_cnt == MEM_TIMEOUT) begin
              r_state   <= ST_HALT;
              r_mem_err <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end else begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end
        end
        ST_HALT: begin
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Saturating performance counters: PC-hold cycles (not while halted) and redirects.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if ((r_state != ST_HALT) && !PCWrite && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (PCSrc && (r_flush_count != 32'hFFFF_FFFF))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign Stall_Cycles = r_stall_cycles;
  assign Flush_Count  = r_flush_count;
`else
  assign Stall_Cycles = 32'd0;
  assign Flush_Count  = 32'd0;
`endif

endmodule
